// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared definitions for the VGA raster generator: 640x480@60
//               default timing, the 12-bit colour type with r/g/b fields and
//               the colour-bar table used by the optional test-pattern build.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // 640x480@60 timing (25 MHz pixel clock)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CNT_W_DEF    = 10;

  // Colour word as delivered by the renderer: {r[3:0], g[3:0], b[3:0]}
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Which of the 8 vertical bars a column falls into (column must be active)
  function automatic logic [2:0] bar_index(input int x, input int h_active);
    return 3'((x * 8) / h_active);
  endfunction

  // Bar colours, left to right
  function automatic rgb12_t bar_colour(input logic [2:0] bar);
    rgb12_t c;
    case (bar)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis counter. Counts 0..TOTAL-1 while en is high
//               and wraps to 0; wrap flags the enabled terminal count so the
//               next axis can be chained from it.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int CNT_W = 10
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold when disabled, wrap to zero after the last position
  always_comb begin
    wrap  = en && (cnt_q == c_last);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk25) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster generator. Stage 0 publishes the
//               pixel being requested (pix_x/pix_y/pix_req/frame_start);
//               stage 1 registers colour, data-enable and both syncs together
//               so they leave the block mutually aligned, one clock late.
//               Build option VGA_TEST_PATTERN_EN replaces the rgb input with
//               eight vertical colour bars; ports and timing are unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CNT_W      = CNT_W_DEF
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic [11:0]      rgb,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  output logic             frame_start,
  output logic [3:0]       red_out,
  output logic [3:0]       green_out,
  output logic [3:0]       blue_out,
  output logic             de,
  output logic             hSync,
  output logic             vSync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_h_active  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_h_sync_lo = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_h_sync_hi = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_v_active  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_sync_lo = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_v_sync_hi = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Reject degenerate timings and counters too narrow for the raster
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_param_check
    $error("vga_timing_gen: zero porch/sync width or CNT_W too small for H/V total");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .CNT_W (CNT_W)
  ) u_h_counter (
    .clk25 (clk25),
    .rst   (rst),
    .en    (1'b1),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .CNT_W (CNT_W)
  ) u_v_counter (
    .clk25 (clk25),
    .rst   (rst),
    .en    (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  // The counters reach (0,0) only through a reset or a full-frame wrap, so a
  // flag set by either marks the origin without a full-width compare of both.
  logic origin_q;
  logic origin_d;

  // Origin flag: high while the counters sit at (0,0)
  always_ff @(posedge clk25) begin
    origin_q <= origin_d;
  end

  assign origin_d = rst || v_wrap;

  // Stage 0: pixel request towards the renderer
  logic active_w;
  assign active_w    = (h_cnt < c_h_active) && (v_cnt < c_v_active);
  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign pix_req     = active_w && !rst;
  assign frame_start = origin_q && !rst;

  // Colour source for the active area
  rgb12_t pix_rgb_w;
`ifdef VGA_TEST_PATTERN_EN
  assign pix_rgb_w = bar_colour(bar_index(int'(h_cnt), H_ACTIVE));
`else
  assign pix_rgb_w = rgb;
`endif

  logic   de_q,    de_d;
  rgb12_t rgb_q,   rgb_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  // Stage 1 next values; blanking forces black so an undriven rgb is masked
  always_comb begin
    de_d    = pix_req;
    rgb_d   = pix_req ? pix_rgb_w : rgb12_t'(12'h000);
    hsync_d = ((h_cnt >= c_h_sync_lo) && (h_cnt < c_h_sync_hi)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d = ((v_cnt >= c_v_sync_lo) && (v_cnt < c_v_sync_hi)) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  // Stage 1 registers: colour, enable and syncs share one clock of latency
  always_ff @(posedge clk25) begin
    if (rst) begin
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
    end else begin
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign de        = de_q;
  assign red_out   = rgb_q.r;
  assign green_out = rgb_q.g;
  assign blue_out  = rgb_q.b;
  assign hSync     = hsync_q;
  assign vSync     = vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Randomised bench for vga_timing_gen on a small 14x7 raster.
//               The driver walks a linear frame position, pushes the expected
//               registered outputs into a queue and the monitor pops and
//               compares them one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int CW = 4;
  localparam int HT = HA + HF + HS + HB;   // 14
  localparam int VT = VA + VF + VS + VB;   // 7
  localparam int FRAME = HT * VT;          // 98
  localparam int NCYC = 3000;

  logic          clk25 = 1'b0;
  logic          rst   = 1'b1;
  logic [11:0]   rgb   = 12'h000;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_req, frame_start, de, hSync, vSync;
  logic [3:0]    red_out, green_out, blue_out;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(CW)
  ) dut (
    .clk25(clk25), .rst(rst), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .frame_start(frame_start),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .de(de), .hSync(hSync), .vSync(vSync)
  );

  always #5 clk25 = ~clk25;

  typedef struct packed {
    logic        de;
    logic [11:0] col;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the registered stage must show for frame position pos
  function automatic exp_t model_out(input int pos, input bit r, input logic [11:0] c);
    exp_t e;
    int h, v;
    bit act;
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    h = pos % HT;
    v = pos / HT;
    act = (h < HA) && (v < VA);
    if (r) begin
      e = '{de: 1'b0, col: 12'h000, hs: 1'b1, vs: 1'b1};
    end else begin
      e.de = act;
`ifdef VGA_TEST_PATTERN_EN
      e.col = act ? bars[(h * 8) / HA] : 12'h000;
`else
      e.col = act ? c : 12'h000;
`endif
      e.hs = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
      e.vs = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
    end
    return e;
  endfunction

  // Monitor: registered outputs appear one edge after their stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk25);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("de", 32'(de), 32'(e.de));
        chk("rgb_out", 32'({red_out, green_out, blue_out}), 32'(e.col));
        chk("hSync", 32'(hSync), 32'(e.hs));
        chk("vSync", 32'(vSync), 32'(e.vs));
      end
    end
  end

  // Driver and stage-0 checks
  initial begin
    int pos, h, v, rst_left, since_fs;
    bit known, r, did_mid, act;
    logic [11:0] c;
    pos = 0; known = 0; did_mid = 0; rst_left = 3; since_fs = -1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk25);
      if (rst_left > 0) begin
        r = 1'b1;
        rst_left--;
      end else if (!did_mid && cyc > 400 && pos == 2 * HT + 6) begin
        r = 1'b1;               // mid-frame reset at h=6, v=2
        did_mid = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        r = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else begin
        r = 1'b0;
      end
      h = pos % HT;
      v = pos / HT;
      act = known && (h < HA) && (v < VA);
      if (!act || r) c = 12'hxxx;                    // don't-care colour
      else if (cyc < 600) c = 12'hA5C;
      else c = 12'($urandom_range(0, 4095));
      rst = r;
      rgb = c;
      #1;
      if (known) begin
        chk("pix_x", 32'(pix_x), 32'(h));
        chk("pix_y", 32'(pix_y), 32'(v));
      end
      chk("pix_req", 32'(pix_req), 32'(act && !r));
      chk("frame_start", 32'(frame_start), 32'(known && !r && pos == 0));
      if (since_fs >= 0) since_fs++;
      if (frame_start === 1'b1) begin
        if (since_fs > 0) chk("frame_period", 32'(since_fs), 32'(FRAME));
        since_fs = 0;
      end
      if (r) since_fs = -1;
      q.push_back(model_out(pos, r, c));
      pos = r ? 0 : (pos + 1) % FRAME;
      known = known || r;
    end
    @(posedge clk25);
    #2;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
